// File: rtl/predictor_gshare_pkg.sv
`default_nettype none
// ============================================================================
// Module   : predictor_gshare_pkg
// Purpose  : Shared defaults and helpers for the gshare branch predictor.
//            The default widths are also what InsFetch and RoB use to size
//            the pred_hist field that travels with each instruction.
// Contents : DEF_INDEX_W, DEF_HIST_W, DEF_CNT_W defaults;
//            pred_taken() counter-MSB test; sat_inc32() saturating increment.
// Revision : 1.0 - initial release
// ============================================================================
package predictor_gshare_pkg;

    localparam int DEF_INDEX_W = 6;
    localparam int DEF_HIST_W  = 6;
    localparam int DEF_CNT_W   = 2;

    // A counter predicts taken when its most significant bit is set.
    function automatic logic pred_taken(input logic [31:0] cnt, input int cnt_w);
        return cnt[cnt_w-1];
    endfunction

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage : predictor_gshare_pkg
`default_nettype wire

// File: rtl/predictor_gshare_bht_counters.sv
`default_nettype none
// ============================================================================
// Module   : predictor_gshare_bht_counters
// Purpose  : Table of 2**INDEX_W saturating counters. One combinational read
//            port (returns the pre-write value) and one synchronous
//            saturating-update port.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_rd_idx        - read index
//            o_rd_cnt        - counter value at i_rd_idx
//            i_wr_en         - apply an update this cycle
//            i_wr_idx        - index being trained
//            i_wr_taken      - 1: count up, 0: count down
// Revision : 1.0 - initial release
// ============================================================================
module predictor_gshare_bht_counters #(
    parameter int INDEX_W  = 6,
    parameter int CNT_W    = 2,
    parameter int INIT_CNT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0]   o_rd_cnt,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic               i_wr_taken
);

    localparam int               c_entries  = 1 << INDEX_W;
    localparam logic [CNT_W-1:0] c_init_cnt = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0] c_max_cnt  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt [c_entries];
    logic [CNT_W-1:0] w_cur_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;

    assign o_rd_cnt  = r_cnt[i_rd_idx];
    assign w_cur_cnt = r_cnt[i_wr_idx];

    always_comb begin
        w_nxt_cnt = w_cur_cnt;
        if (i_wr_taken && (w_cur_cnt != c_max_cnt)) begin
            w_nxt_cnt = w_cur_cnt + CNT_W'(1);
        end else if (!i_wr_taken && (w_cur_cnt != '0)) begin
            w_nxt_cnt = w_cur_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_entries; i++) begin
                r_cnt[i] <= c_init_cnt;
            end
        end else if (i_wr_en) begin
            r_cnt[i_wr_idx] <= w_nxt_cnt;
        end
    end

endmodule : predictor_gshare_bht_counters
`default_nettype wire

// File: rtl/predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module   : predictor_gshare
// Purpose  : gshare predictor. Counter table indexed by PC bits XOR global
//            history. Speculative GHR shifts at fetch; committed GHR shifts
//            at RoB commit and restores the speculative copy on a flush.
// Ports    : clk_in, rst_in, rdy_in           - clock, sync reset, global stall
//            if_valid, if_is_br, if_pc        - fetch query
//            tojump, pred_hist                - prediction and GHR used for it
//            rob_valid, rob_now_pc, rob_hist,
//            should_jump, rob_mispredict      - commit-time training
//            br_cnt, miss_cnt                 - saturating perf counters
// Revision : 1.0 - initial release
// ============================================================================
module predictor_gshare
    import predictor_gshare_pkg::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int HIST_W   = DEF_HIST_W,
    parameter int PC_LSB   = 1,
    parameter int INIT_CNT = 2**(CNT_W-1) - 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_valid,
    input  logic              if_is_br,
    input  logic [31:0]       if_pc,
    output logic              tojump,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              rob_valid,
    input  logic [31:0]       rob_now_pc,
    input  logic [HIST_W-1:0] rob_hist,
    input  logic              should_jump,
    input  logic              rob_mispredict,
    output logic [31:0]       br_cnt,
    output logic [31:0]       miss_cnt
);

    logic [HIST_W-1:0]  r_spec_ghr;
    logic [HIST_W-1:0]  r_commit_ghr;
    logic [31:0]        r_br_cnt;
    logic [31:0]        r_miss_cnt;

    logic [HIST_W-1:0]  w_commit_ghr_nxt;
    logic [HIST_W-1:0]  w_spec_ghr_shift;
    logic [INDEX_W-1:0] w_rd_idx;
    logic [INDEX_W-1:0] w_wr_idx;
    logic [CNT_W-1:0]   w_rd_cnt;
    logic               w_tojump;
    logic               w_train;
    logic               w_unused_pc;

    assign w_rd_idx = if_pc[PC_LSB +: INDEX_W] ^ INDEX_W'(r_spec_ghr);
    assign w_wr_idx = rob_now_pc[PC_LSB +: INDEX_W] ^ INDEX_W'(rob_hist);
    assign w_train  = rdy_in & rob_valid;
    assign w_tojump = pred_taken(32'(w_rd_cnt), CNT_W);

    // PC bits outside the index window do not take part in prediction.
    assign w_unused_pc = &{1'b0, if_pc, rob_now_pc};

    generate
        if (HIST_W == 1) begin : g_hist_one
            assign w_commit_ghr_nxt = should_jump;
            assign w_spec_ghr_shift = w_tojump;
        end else begin : g_hist_multi
            assign w_commit_ghr_nxt = {r_commit_ghr[HIST_W-2:0], should_jump};
            assign w_spec_ghr_shift = {r_spec_ghr[HIST_W-2:0], w_tojump};
        end
    endgenerate

    predictor_gshare_bht_counters #(
        .INDEX_W  (INDEX_W),
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_bht (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_rd_idx   (w_rd_idx),
        .o_rd_cnt   (w_rd_cnt),
        .i_wr_en    (w_train),
        .i_wr_idx   (w_wr_idx),
        .i_wr_taken (should_jump)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_spec_ghr   <= '0;
            r_commit_ghr <= '0;
            r_br_cnt     <= '0;
            r_miss_cnt   <= '0;
        end else if (rdy_in) begin
            // A flush restores history to the post-commit value; any fetch in
            // the same cycle is on the squashed path and must not shift.
            if (rob_valid && rob_mispredict) begin
                r_spec_ghr <= w_commit_ghr_nxt;
            end else if (if_valid && if_is_br) begin
                r_spec_ghr <= w_spec_ghr_shift;
            end
            if (rob_valid) begin
                r_commit_ghr <= w_commit_ghr_nxt;
                r_br_cnt     <= sat_inc32(r_br_cnt);
                if (rob_mispredict) begin
                    r_miss_cnt <= sat_inc32(r_miss_cnt);
                end
            end
        end
    end

    assign tojump    = w_tojump;
    assign pred_hist = r_spec_ghr;
    assign br_cnt    = r_br_cnt;
    assign miss_cnt  = r_miss_cnt;

endmodule : predictor_gshare
`default_nettype wire

// File: tb/tb_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module   : tb_predictor_gshare
// Purpose  : Directed, table-driven bench for predictor_gshare (defaults:
//            INDEX_W=6, CNT_W=2, HIST_W=6, PC_LSB=1). Each record gives the
//            inputs for one cycle and the outputs expected just before the
//            clock edge that consumes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_predictor_gshare;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_valid;
    logic        if_is_br;
    logic [31:0] if_pc;
    logic        tojump;
    logic [5:0]  pred_hist;
    logic        rob_valid;
    logic [31:0] rob_now_pc;
    logic [5:0]  rob_hist;
    logic        should_jump;
    logic        rob_mispredict;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_in = ~clk_in;

    predictor_gshare dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .if_valid       (if_valid),
        .if_is_br       (if_is_br),
        .if_pc          (if_pc),
        .tojump         (tojump),
        .pred_hist      (pred_hist),
        .rob_valid      (rob_valid),
        .rob_now_pc     (rob_now_pc),
        .rob_hist       (rob_hist),
        .should_jump    (should_jump),
        .rob_mispredict (rob_mispredict),
        .br_cnt         (br_cnt),
        .miss_cnt       (miss_cnt)
    );

    always @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            assert (!(rob_mispredict && !rob_valid))
                else $error("rob_mispredict asserted without rob_valid");
        end
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ifv;
        logic        ifbr;
        logic [31:0] ifpc;
        logic        robv;
        logic [31:0] robpc;
        logic [5:0]  robh;
        logic        sj;
        logic        mp;
        logic        e_tj;
        logic [5:0]  e_hist;
        logic [31:0] e_br;
        logic [31:0] e_miss;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic ifv,
                                input logic ifbr, input logic [31:0] ifpc,
                                input logic robv, input logic [31:0] robpc,
                                input logic [5:0] robh, input logic sj, input logic mp,
                                input logic e_tj, input logic [5:0] e_hist,
                                input logic [31:0] e_br, input logic [31:0] e_miss);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.ifv = ifv; v.ifbr = ifbr; v.ifpc = ifpc;
        v.robv = robv; v.robpc = robpc; v.robh = robh; v.sj = sj; v.mp = mp;
        v.e_tj = e_tj; v.e_hist = e_hist; v.e_br = e_br; v.e_miss = e_miss;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic e_tj, input logic [5:0] e_hist,
                              input logic [31:0] e_br, input logic [31:0] e_miss);
        chk({tag, " tojump"},    32'(tojump),    32'(e_tj));
        chk({tag, " pred_hist"}, 32'(pred_hist), 32'(e_hist));
        chk({tag, " br_cnt"},    br_cnt,         e_br);
        chk({tag, " miss_cnt"},  miss_cnt,       e_miss);
    endtask

    initial begin
        // Fields: rst rdy ifv ifbr ifpc | robv robpc robh sj mp | tojump hist br miss
        // -- first prediction after reset, then train index 0 up and down
        vq.push_back(mk(0,1,1,1,32'h100, 0,32'h0,  6'd0,0,0, 0,6'd0,0,0));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h100,6'd0,1,0, 0,6'd0,0,0));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h100,6'd0,1,0, 1,6'd0,1,0));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h100,6'd0,1,0, 1,6'd0,2,0));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h100,6'd0,0,0, 1,6'd0,3,0));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h100,6'd0,0,0, 1,6'd0,4,0));
        vq.push_back(mk(0,1,0,0,32'h100, 0,32'h0,  6'd0,0,0, 0,6'd0,5,0));
        // -- speculative shift 1,0,1 (index 5 trained taken first)
        vq.push_back(mk(0,1,0,0,32'h10A, 1,32'h10A,6'd0,1,0, 0,6'd0,5,0));
        vq.push_back(mk(0,1,1,1,32'h10A, 0,32'h0,  6'd0,0,0, 1,6'd0,6,0));
        vq.push_back(mk(0,1,1,1,32'h100, 0,32'h0,  6'd0,0,0, 0,6'd1,6,0));
        vq.push_back(mk(0,1,1,1,32'h10E, 0,32'h0,  6'd0,0,0, 1,6'd2,6,0));
        vq.push_back(mk(0,1,0,0,32'h100, 0,32'h0,  6'd0,0,0, 1,6'd5,6,0));
        // -- mid-stream reset with live traffic, then everything back to reset values
        vq.push_back(mk(1,1,1,1,32'h100, 1,32'h100,6'd0,1,1, 1,6'd5,6,0));
        vq.push_back(mk(0,1,0,0,32'h10A, 0,32'h0,  6'd0,0,0, 0,6'd0,0,0));
        // -- recovery: commit_ghr=000011, then mispredict (not taken) with a fetch
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h100,6'd0,1,0, 0,6'd0,0,0));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h100,6'd0,1,0, 1,6'd0,1,0));
        vq.push_back(mk(0,1,1,1,32'h100, 1,32'h100,6'd0,0,1, 1,6'd0,2,0));
        vq.push_back(mk(0,1,0,0,32'h100, 0,32'h0,  6'd0,0,0, 0,6'd6,3,1));
        // -- aliasing on index 1 (spec_ghr=6: pc 0x10E->idx1, pc 0x10C->idx0)
        vq.push_back(mk(0,1,0,0,32'h10E, 1,32'h102,6'd0,1,0, 0,6'd6,3,1));
        vq.push_back(mk(0,1,0,0,32'h10E, 1,32'h100,6'd1,1,0, 1,6'd6,4,1));
        vq.push_back(mk(0,1,0,0,32'h10C, 1,32'h100,6'd1,0,0, 1,6'd6,5,1));
        vq.push_back(mk(0,1,0,0,32'h10E, 1,32'h100,6'd1,0,0, 1,6'd6,6,1));
        vq.push_back(mk(0,1,0,0,32'h10E, 0,32'h0,  6'd0,0,0, 0,6'd6,7,1));
        vq.push_back(mk(0,1,0,0,32'h10C, 0,32'h0,  6'd0,0,0, 1,6'd6,7,1));
        // -- same-index read during write sees old counter, new one next cycle
        vq.push_back(mk(0,1,0,0,32'h10C, 1,32'h10C,6'd6,0,0, 1,6'd6,7,1));
        vq.push_back(mk(0,1,0,0,32'h10C, 0,32'h0,  6'd0,0,0, 0,6'd6,8,1));
        // -- stall: commit + mispredict + fetch all ignored
        vq.push_back(mk(0,0,1,1,32'h10C, 1,32'h10C,6'd6,1,1, 0,6'd6,8,1));
        vq.push_back(mk(0,1,0,0,32'h10C, 0,32'h0,  6'd0,0,0, 0,6'd6,8,1));
        // -- reset, then 5 commits with 2 mispredicts
        vq.push_back(mk(1,1,0,0,32'h10C, 0,32'h0,  6'd0,0,0, 0,6'd6,8,1));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h140,6'd0,1,0, 0,6'd0,0,0));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h140,6'd0,1,1, 0,6'd0,1,0));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h140,6'd0,1,0, 0,6'd3,2,1));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h140,6'd0,1,1, 0,6'd3,3,1));
        vq.push_back(mk(0,1,0,0,32'h100, 1,32'h140,6'd0,1,0, 0,6'd15,4,2));
        vq.push_back(mk(0,1,0,0,32'h100, 0,32'h0,  6'd0,0,0, 0,6'd15,5,2));

        // Initial reset
        rst_in = 1'b1; rdy_in = 1'b1; if_valid = 1'b0; if_is_br = 1'b0;
        if_pc = 32'h100; rob_valid = 1'b0; rob_now_pc = '0; rob_hist = '0;
        should_jump = 1'b0; rob_mispredict = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        check_outs("reset", 1'b0, 6'd0, 32'd0, 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            rst_in         = vq[i].rst;
            rdy_in         = vq[i].rdy;
            if_valid       = vq[i].ifv;
            if_is_br       = vq[i].ifbr;
            if_pc          = vq[i].ifpc;
            rob_valid      = vq[i].robv;
            rob_now_pc     = vq[i].robpc;
            rob_hist       = vq[i].robh;
            should_jump    = vq[i].sj;
            rob_mispredict = vq[i].mp;
            #1;
            check_outs($sformatf("vec%0d", i), vq[i].e_tj, vq[i].e_hist,
                       vq[i].e_br, vq[i].e_miss);
            @(posedge clk_in);
            #1;
        end

        // Multi-cycle: after the last vector, a long stall holds every output
        rst_in = 1'b0; rdy_in = 1'b0; if_valid = 1'b1; if_is_br = 1'b1;
        if_pc = 32'h100; rob_valid = 1'b1; rob_now_pc = 32'h100; rob_hist = '0;
        should_jump = 1'b1; rob_mispredict = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        check_outs("long_stall", 1'b0, 6'd15, 32'd5, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_predictor_gshare
`default_nettype wire

// File: doc/predictor_gshare.md
Name: predictor_gshare

Overview:
Parametrised gshare branch predictor and successor to the per-PC 2-bit bimodal table. It indexes a table of saturating counters with PC bits XOR a global history register (GHR). The GHR is speculatively updated at fetch and recovered from a committed GHR on a RoB mispredict flush. It sits between InsFetch (prediction query) and RoB (commit-time training), and exposes commit and mispredict performance counters.

Parameters:
INDEX_W, 6, log2 of table entries (default 64 entries).
CNT_W, 2, counter width. Predict taken when the counter MSB is 1.
HIST_W, 6, GHR length. Must satisfy 1 <= HIST_W <= INDEX_W.
PC_LSB, 1, lowest PC bit used in the index.
INIT_CNT, 2**(CNT_W-1)-1, counter reset value (weakly not-taken).

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global stall. When low, all state holds.
if_valid  in  1  fetch slot holds a valid instruction
if_is_br  in  1  fetched instruction is a conditional branch
if_pc  in  32  fetch PC
tojump  out  1  prediction for if_pc
pred_hist  out  HIST_W  spec GHR used for this prediction; travels with the instruction to RoB
rob_valid  in  1  a conditional branch commits this cycle
rob_now_pc  in  32  committing branch PC
rob_hist  in  HIST_W  pred_hist captured at that branch's fetch
should_jump  in  1  resolved direction
rob_mispredict  in  1  committing branch was mispredicted; pipeline flush
br_cnt  out  32  committed branch count
miss_cnt  out  32  mispredicted branch count

Behaviour:
- Index function: idx(pc,h) = pc[PC_LSB+INDEX_W-1:PC_LSB] XOR zero-extend(h) to INDEX_W.
- Prediction is combinational:
  - tojump = cnt[idx(if_pc, spec_ghr)][CNT_W-1].
  - pred_hist = spec_ghr.
  - Both are valid regardless of if_valid.
- Table read during write returns the old value; an update is visible the next cycle.
- Reset (rst_in=1 at posedge, irrespective of rdy_in):
  - all counters = INIT_CNT;
  - spec_ghr = 0, commit_ghr = 0;
  - br_cnt = 0, miss_cnt = 0.
  - Outputs after reset: tojump = INIT_CNT MSB (0 by default), pred_hist = 0, br_cnt = 0, miss_cnt = 0.
- All updates below require rdy_in=1. With rdy_in=0, inputs are ignored and state holds.
- Training, when rob_valid=1:
  - Counter c at idx(rob_now_pc, rob_hist) becomes c+1 if should_jump and c < 2**CNT_W-1.
  - It becomes c-1 if !should_jump and c > 0. Otherwise it is unchanged (saturating).
  - commit_ghr <= {commit_ghr[HIST_W-2:0], should_jump}. For HIST_W=1 this is just should_jump.
  - br_cnt += 1, saturating at 0xFFFFFFFF.
  - If rob_mispredict=1, miss_cnt += 1, saturating.
- rob_mispredict with rob_valid=0 is illegal. The bench asserts against it and the RTL ignores it.
- Speculative history, priority high to low:
  1. rob_valid & rob_mispredict: spec_ghr <= {commit_ghr[HIST_W-2:0], should_jump}, i.e. the post-commit value. A same-cycle fetch is discarded, because it is on the flushed path.
  2. if_valid & if_is_br: spec_ghr <= {spec_ghr[HIST_W-2:0], tojump}.
  3. Otherwise spec_ghr holds.
- Fetch shift and commit training in the same cycle without a mispredict are independent and both occur.
- Fetch and commit to the same table index in one cycle: the fetch sees the old counter.
- Two writes per cycle are impossible (single commit port).
- No latency from commit to prediction beyond one clock.

Decomposition:
- const.v gains defines for the default INDEX_W, HIST_W and CNT_W, plus a `PRED_TAKEN macro (counter MSB test) shared with InsFetch and RoB for pred_hist width.
- One sub-module, bht_counters: the counter array with a combinational read port and a synchronous saturating-update port, parametrised on INDEX_W, CNT_W and INIT_CNT.
- GHR logic and perf counters stay in predictor_gshare.

Test Plan:
- Reset then if_pc=0x100 with if_is_br=1 -> tojump=0 and pred_hist=0. Next cycle (prediction 0 shifted in) pred_hist=0.
- Train: two commits of pc=0x100, rob_hist=0, should_jump=1 -> counter[0] 01→10→11 and tojump=1 for if_pc=0x100 with spec_ghr=0. A third taken commit keeps 11. One not-taken commit -> 10, tojump still 1. A second not-taken -> 01, tojump 0.
- Speculative shift: fetch three branches predicted 1,0,1 -> spec_ghr=6'b000101.
- Recovery:
  - Set commit_ghr=6'b000011 via two taken commits.
  - Then commit rob_valid=1, rob_mispredict=1, should_jump=0, with a simultaneous branch fetch.
  - Required: spec_ghr=6'b000110 next cycle, and the fetch is ignored.
- Aliasing:
  - pc=0x102 with rob_hist=0 trains index 1.
  - pc=0x100 with rob_hist=6'b000001 then reads the same counter.
  - pc=0x100 with hist 0 (index 0) is unaffected.
- Stall and counters:
  - rob_valid=1 while rdy_in=0 -> no table, GHR or count change.
  - Then 5 commits, 2 of them mispredicted -> br_cnt=5, miss_cnt=2.
  - rst_in mid-stream -> all state returns to reset values next cycle.
